// File: rtl/neopixel_rx.sv
// neopixel_rx: WS2812 serial line decoder.
//
// Oversamples din, classifies each high pulse as a 0/1 bit by its length,
// assembles NBITS bits into a shadow buffer and commits the shadow to
// framebuf when the line has been low for RESET_CYC samples (latch gap).
//
// Ports:
//   clk          oversampling clock
//   nrst         synchronous active-low reset
//   din          asynchronous serial data line
//   framebuf     last complete frame, received bit i at framebuf[i]
//   frame_valid  one-cycle pulse when framebuf updates
//   err          one-cycle pulse on short frame, overflow, stuck-high line
//                or filtered glitch
//   busy         high while a frame is in progress (bit count nonzero)
//
// Build option: define NEOPIXEL_RX_GLITCH_EN to drop high pulses shorter
// than GLITCH_CYC samples (err pulse, no bit stored, low timing continues).
module neopixel_rx #(
    parameter int NBITS      = 384,
    parameter int T1_MIN_CYC = 8,
    parameter int RESET_CYC  = 800,
    parameter int GLITCH_CYC = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             din,
    output logic [NBITS-1:0] framebuf,
    output logic             frame_valid,
    output logic             err,
    output logic             busy
);
    localparam int CW = $clog2(RESET_CYC + 1);
    localparam int BW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(RESET_CYC);
    localparam logic [CW-1:0] T1_THR     = CW'(T1_MIN_CYC);
    localparam logic [CW-1:0] GLITCH_THR = CW'(GLITCH_CYC);
    localparam logic [BW-1:0] BIT_MAX    = BW'(NBITS);
`ifdef NEOPIXEL_RX_GLITCH_EN
    localparam logic GLITCH_EN = 1'b1;
`else
    localparam logic GLITCH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t           state;
    logic             s_meta, s, s_prev;
    logic [CW-1:0]    hcnt, lcnt, hcnt_inc, lcnt_inc;
    logic [BW-1:0]    bitcnt;
    logic             discard;
    logic [NBITS-1:0] shadow;
    logic             rise, glitch;

    assign rise   = s & ~s_prev;
    // Evaluated only at a falling edge (s low while in HIGH).
    assign glitch = GLITCH_EN & (hcnt < GLITCH_THR);
    assign busy   = (bitcnt != '0);

    always_comb begin
        hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + CW'(1);
        lcnt_inc = (lcnt == CNT_MAX) ? lcnt : lcnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s_meta      <= 1'b0;
            s           <= 1'b0;
            s_prev      <= 1'b0;
            state       <= SYNC;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            discard     <= 1'b0;
            shadow      <= '0;
            framebuf    <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            s_meta      <= din;
            s           <= s_meta;
            s_prev      <= s;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            case (state)
                // Only a full latch gap of low samples lets bits in.
                SYNC: begin
                    if (s) begin
                        lcnt <= '0;
                    end else if (lcnt_inc == CNT_MAX) begin
                        lcnt  <= '0;
                        state <= IDLE;
                    end else begin
                        lcnt <= lcnt_inc;
                    end
                end
                IDLE: begin
                    if (rise) begin
                        hcnt  <= CW'(1);
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    if (s) begin
                        hcnt <= hcnt_inc;
                        if (hcnt_inc == CNT_MAX) begin
                            // Stuck-high line: drop the frame and resync.
                            err     <= 1'b1;
                            bitcnt  <= '0;
                            discard <= 1'b0;
                            lcnt    <= '0;
                            state   <= SYNC;
                        end
                    end else if (glitch) begin
                        // Pulse ignored; the surrounding low time keeps counting.
                        err <= 1'b1;
                        if (bitcnt == '0) begin
                            state <= IDLE;
                        end else begin
                            lcnt  <= lcnt_inc;
                            state <= LOW;
                        end
                    end else begin
                        lcnt  <= CW'(1);
                        state <= LOW;
                        if (bitcnt == BIT_MAX) begin
                            // Only the first overflowing bit reports.
                            if (!discard) err <= 1'b1;
                            discard <= 1'b1;
                        end else begin
                            shadow[bitcnt] <= (hcnt >= T1_THR);
                            bitcnt         <= bitcnt + BW'(1);
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        hcnt  <= CW'(1);
                        state <= HIGH;
                    end else if (lcnt_inc == CNT_MAX) begin
                        if (!discard) begin
                            if (bitcnt == BIT_MAX) begin
                                framebuf    <= shadow;
                                frame_valid <= 1'b1;
                            end else if (bitcnt != '0) begin
                                err <= 1'b1;
                            end
                        end
                        bitcnt  <= '0;
                        discard <= 1'b0;
                        lcnt    <= '0;
                        state   <= IDLE;
                    end else begin
                        lcnt <= lcnt_inc;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: doc/neopixel_rx.md
# neopixel_rx

WS2812 ("NeoPixel") serial line decoder: oversamples a single pulse-width-encoded data line, classifies each high pulse as a 0 or 1 bit, and assembles a complete frame into a parallel framebuffer that is committed on the latch (reset) gap. It is the receiving end of the LED data line. Uses are loop-back checking of the LED driver output and accepting pixel data from an external controller.

## Interface

Parameters:
- NBITS, 384: bits per frame (48 bytes).
- T1_MIN_CYC, 8: high-pulse length threshold in clk cycles; high >= T1_MIN_CYC decodes as 1, otherwise 0.
- RESET_CYC, 800: low time in clk cycles that marks the latch gap; high time of RESET_CYC marks a stuck line.
- GLITCH_CYC, 2: high pulses shorter than this are filtered; only used when the glitch filter is compiled in.

Ports:
- clk  in  1  oversampling clock (16 MHz nominal).
- nrst  in  1  reset, synchronous, active-low.
- din  in  1  asynchronous serial data line.
- framebuf  out  NBITS  last complete frame; received bit i lands in framebuf[i].
- frame_valid  out  1  one-cycle pulse when framebuf updates.
- err  out  1  one-cycle pulse on frame error (short, overflow, stuck-high, filtered glitch).
- busy  out  1  high while a frame is in progress (bit count nonzero).

## Operation

- din passes through a 2-flop synchronizer; all logic uses the synchronized sample s and its previous value for edge detection.
- States: SYNC, IDLE, HIGH, LOW.
- SYNC (entered on reset): waits for RESET_CYC consecutive low samples, then goes to IDLE. No bits are accepted in SYNC.
- IDLE: waits for a rising edge, then enters HIGH with hcnt=1.
- HIGH: hcnt increments, saturating at RESET_CYC.
  - If hcnt reaches RESET_CYC: pulse err, discard the frame, zero the bit count, go to SYNC.
  - On a falling edge: classify bit = (hcnt >= T1_MIN_CYC) and write it to shadow[bitcnt], then increment bitcnt. Enter LOW with lcnt=1.
  - If bitcnt==NBITS at that falling edge (overflow): pulse err, set the internal discard flag, drop the bit.
- LOW: lcnt increments, saturating.
  - On a rising edge: go to HIGH with hcnt=1.
  - If lcnt reaches RESET_CYC (end of frame):
    - bitcnt==NBITS and not discarding: copy shadow to framebuf, pulse frame_valid.
    - bitcnt in 1..NBITS-1: pulse err; framebuf unchanged.
    - Discard flag set: no further pulse.
  - In every case bitcnt=0, the discard flag is cleared, and the state goes to IDLE.
- Counter widths are $clog2(RESET_CYC+1); bitcnt width is $clog2(NBITS+1).
- frame_valid and err are never asserted in the same cycle.
- Reset mid-frame discards shadow contents and returns to SYNC.

## Timing

- Reset values: framebuf=0, frame_valid=0, err=0, busy=0, state SYNC, all counters 0.
- din to s latency: 2 cycles.
- frame_valid and the framebuf update occur the cycle after the low sample that makes lcnt equal RESET_CYC. framebuf is stable at all other times.
- err is registered one cycle after the triggering sample.
- busy rises the cycle after the first bit is stored and falls with frame end or discard.
- Minimum valid bit period is 2 cycles (1 high, 1 low) when the glitch filter is compiled out.

## Configuration

- NEOPIXEL_RX_GLITCH_EN defined: a falling edge with hcnt < GLITCH_CYC stores no bit and does not change bitcnt. It pulses err, and LOW timing continues as if the pulse never occurred: lcnt is not restarted.
- Undefined: every high pulse of 1 or more cycles is a bit, and GLITCH_CYC is unused.

## Test plan

Bench timing: 16 MHz clk; bit 0 = 6 high / 14 low cycles; bit 1 = 12 high / 8 low cycles.

- Good frame: reset, 800 low, 384 bits with bit i = i%2, then 800 low. Expect exactly one frame_valid pulse, framebuf = {192{2'b10}}, err never high, busy high during the frame only.
- Short frame: 100 bits then 800 low. Expect one err pulse, no frame_valid, framebuf unchanged (previous value or 0).
- Overflow: 385 bits then 800 low. Expect err on the 385th falling edge, no frame_valid, framebuf unchanged. A following good frame commits normally.
- Stuck high: mid-frame, din high 800 cycles, then low. Expect one err pulse and a return to SYNC. Bits sent less than 800 low cycles after the stuck period are ignored; a full gap then a good frame gives frame_valid.
- Glitch: a 1-cycle high pulse inserted between bits 10 and 11 of a good frame. With NEOPIXEL_RX_GLITCH_EN: err pulse, then frame_valid with the correct framebuf. Without it: the pulse decodes as a 0 bit, giving an overflow err and no frame_valid.
- Reset mid-frame: nrst low for 1 cycle after 200 bits. Expect all outputs 0. The remaining bits are ignored until 800 low cycles; the next full frame gives frame_valid.
